// File: rtl/demux1_2_2bit_reg_pkg.sv
// Shared constants for the registered 1:2 demultiplexer: lane encodings and
// default widths used by the interface, the lane register and the top.
package demux_pkg;

  localparam logic LANE_A = 1'b0;
  localparam logic LANE_B = 1'b1;

  localparam int DEF_WIDTH = 2;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/demux1_2_2bit_reg_if.sv
// Bus bundle for the demultiplexer: the muxed input stream, both output lanes
// with their handshakes, the per-lane beat counters and the counter clear.
interface demux_if
  import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);

    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] outA_data;
    logic             outA_valid;
    logic             outA_ready;

    logic [WIDTH-1:0] outB_data;
    logic             outB_valid;
    logic             outB_ready;

    logic [CNT_W-1:0] cntA;
    logic [CNT_W-1:0] cntB;
    logic             clr_cnt;

    // Source/consumer side: drives the stream and the lane readies.
    modport master (
        output in_data, in_sel, in_valid, outA_ready, outB_ready, clr_cnt,
        input  in_ready, outA_data, outA_valid, outB_data, outB_valid, cntA, cntB
    );

    // Demultiplexer side.
    modport slave (
        input  in_data, in_sel, in_valid, outA_ready, outB_ready, clr_cnt,
        output in_ready, outA_data, outA_valid, outB_data, outB_valid, cntA, cntB
    );

endinterface

// File: rtl/demux1_2_2bit_reg_lane.sv
// One output lane: a single-entry hold register with valid/ready handshake and
// a saturating count of beats loaded into it.
module demux_lane_reg
  import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready_out,
    input  logic             clr,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             free,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A full register can still accept when its consumer drains it this cycle.
    assign free = ~valid | ready_out;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; the data register is reset too so the lane
    // never presents X after reset, even though valid already qualifies it.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= data_in;
            valid <= 1'b1;
        end else if (valid && ready_out) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/demux1_2_2bit_reg.sv
// Registered 1:2 demultiplexer: routes each accepted beat of the muxed stream
// into lane A or lane B according to in_sel, one beat per cycle per lane.
module demux1_2_2bit_reg
  import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic   clk,
    input logic   reset_L,
    demux_if.slave bus
);

    logic free_a;
    logic free_b;
    logic accept;
    logic load_a;
    logic load_b;

    // in_ready depends only on the select and the selected lane's state/ready.
    assign bus.in_ready = (bus.in_sel == LANE_B) ? free_b : free_a;
    assign accept       = bus.in_valid & bus.in_ready;
    assign load_a       = accept & (bus.in_sel == LANE_A);
    assign load_b       = accept & (bus.in_sel == LANE_B);

    demux_lane_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_lane_a (
        .clk       (clk),
        .reset_L   (reset_L),
        .load      (load_a),
        .data_in   (bus.in_data),
        .ready_out (bus.outA_ready),
        .clr       (bus.clr_cnt),
        .data      (bus.outA_data),
        .valid     (bus.outA_valid),
        .free      (free_a),
        .cnt       (bus.cntA)
    );

    demux_lane_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_lane_b (
        .clk       (clk),
        .reset_L   (reset_L),
        .load      (load_b),
        .data_in   (bus.in_data),
        .ready_out (bus.outB_ready),
        .clr       (bus.clr_cnt),
        .data      (bus.outB_data),
        .valid     (bus.outB_valid),
        .free      (free_b),
        .cnt       (bus.cntB)
    );

endmodule

// File: tb/tb_demux1_2_2bit_reg.sv
// Self-checking bench: two instances (8-bit and 2-bit counters) driven with the
// same stream, compared every cycle against a lane-level behavioural model.
module tb_demux1_2_2bit_reg;

    logic clk = 1'b0;
    logic reset_L;

    always #5 clk = ~clk;

    demux_if #(.WIDTH(2), .CNT_W(8)) bm ();
    demux_if #(.WIDTH(2), .CNT_W(2)) bs ();

    assign bs.in_data    = bm.in_data;
    assign bs.in_sel     = bm.in_sel;
    assign bs.in_valid   = bm.in_valid;
    assign bs.outA_ready = bm.outA_ready;
    assign bs.outB_ready = bm.outB_ready;
    assign bs.clr_cnt    = bm.clr_cnt;

    demux1_2_2bit_reg #(.WIDTH(2), .CNT_W(8)) u_main (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bm.slave)
    );

    demux1_2_2bit_reg #(.WIDTH(2), .CNT_W(2)) u_small (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bs.slave)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Model state indexed [instance][lane]; lane 0 = A, lane 1 = B.
    bit       m_valid [2][2];
    int       m_data  [2][2];
    int       m_cnt   [2][2];
    const int cnt_max [2] = '{255, 3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 2; k++) begin
                m_valid[d][k] = 1'b0;
                m_data[d][k]  = 0;
                m_cnt[d][k]   = 0;
            end
    endtask

    function automatic bit lane_ready(input int k);
        return (k == 0) ? bm.outA_ready : bm.outB_ready;
    endfunction

    task automatic check_outputs();
        check("main.outA_data",  32'(bm.outA_data),  32'(m_data[0][0]));
        check("main.outA_valid", 32'(bm.outA_valid), 32'(m_valid[0][0]));
        check("main.outB_data",  32'(bm.outB_data),  32'(m_data[0][1]));
        check("main.outB_valid", 32'(bm.outB_valid), 32'(m_valid[0][1]));
        check("main.cntA",       32'(bm.cntA),       32'(m_cnt[0][0]));
        check("main.cntB",       32'(bm.cntB),       32'(m_cnt[0][1]));
        check("small.outA_data", 32'(bs.outA_data),  32'(m_data[1][0]));
        check("small.outB_data", 32'(bs.outB_data),  32'(m_data[1][1]));
        check("small.cntA",      32'(bs.cntA),       32'(m_cnt[1][0]));
        check("small.cntB",      32'(bs.cntB),       32'(m_cnt[1][1]));
    endtask

    // One clock: inputs are already set just after the previous edge.
    task automatic cycle(output bit accepted);
        int  sel;
        bit  exp_rdy;
        #1;
        sel     = int'(bm.in_sel);
        exp_rdy = !m_valid[0][sel] || lane_ready(sel);
        check("main.in_ready",  32'(bm.in_ready), 32'(exp_rdy));
        check("small.in_ready", 32'(bs.in_ready), 32'(exp_rdy));
        accepted = bm.in_valid && exp_rdy;
        @(posedge clk);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 2; k++) begin
                if (accepted && sel == k) begin
                    m_data[d][k]  = int'(bm.in_data);
                    m_valid[d][k] = 1'b1;
                end else if (m_valid[d][k] && lane_ready(k)) begin
                    m_valid[d][k] = 1'b0;
                end
                if (bm.clr_cnt)
                    m_cnt[d][k] = 0;
                else if (accepted && sel == k && m_cnt[d][k] < cnt_max[d])
                    m_cnt[d][k]++;
            end
        #1;
        check_outputs();
    endtask

    initial begin
        bit acc;
        bit stalled;

        reset_L       = 1'b0;
        bm.in_data    = '0;
        bm.in_sel     = 1'b0;
        bm.in_valid   = 1'b0;
        bm.outA_ready = 1'b0;
        bm.outB_ready = 1'b0;
        bm.clr_cnt    = 1'b0;
        model_reset();
        #12;
        check_outputs();
        reset_L = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-run: fill lane A with consumer stalled, then pull reset.
        bm.in_valid = 1'b1; bm.in_sel = 1'b0; bm.in_data = 2'b10;
        cycle(acc);
        bm.in_valid = 1'b0;
        check("outA_valid before reset", 32'(bm.outA_valid), 32'd1);
        #2 reset_L = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("outA_valid in reset", 32'(bm.outA_valid), 32'd0);
        #2 reset_L = 1'b1;
        #1;
        check("in_ready after reset", 32'(bm.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Routing sweep, one beat per cycle, both consumers always ready.
        bm.outA_ready = 1'b1; bm.outB_ready = 1'b1; bm.in_valid = 1'b1;
        for (int s = 0; s < 2; s++)
            for (int v = 0; v < 4; v++) begin
                bm.in_sel  = s[0];
                bm.in_data = v[1:0];
                cycle(acc);
            end
        check("sweep cntA", 32'(bm.cntA), 32'd4);
        check("sweep cntB", 32'(bm.cntB), 32'd4);
        check("sweep small cntA saturated", 32'(bs.cntA), 32'd3);

        // Backpressure on lane A.
        bm.in_valid = 1'b0;
        cycle(acc);
        bm.outA_ready = 1'b0;
        bm.in_valid = 1'b1; bm.in_sel = 1'b0; bm.in_data = 2'b01;
        cycle(acc);
        bm.in_data = 2'b10;
        #1;
        check("stall in_ready", 32'(bm.in_ready), 32'd0);
        cycle(acc);
        check("stall holds outA_data", 32'(bm.outA_data), 32'd1);
        bm.outA_ready = 1'b1;
        cycle(acc);
        check("release outA_data", 32'(bm.outA_data), 32'd2);
        check("release outA_valid", 32'(bm.outA_valid), 32'd1);

        // Cross-lane: A full and stalled, B loads.
        bm.outA_ready = 1'b0; bm.outB_ready = 1'b0;
        bm.in_sel = 1'b1; bm.in_data = 2'b11;
        #1;
        check("cross in_ready", 32'(bm.in_ready), 32'd1);
        cycle(acc);
        check("cross outB_data", 32'(bm.outB_data), 32'd3);
        check("cross outA_data", 32'(bm.outA_data), 32'd2);
        check("cross outA_valid", 32'(bm.outA_valid), 32'd1);

        // Counter saturation and clear-with-accept priority.
        bm.in_valid = 1'b0; bm.clr_cnt = 1'b1; bm.outB_ready = 1'b1;
        cycle(acc);
        bm.clr_cnt = 1'b0; bm.in_valid = 1'b1; bm.in_sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bm.in_data = 2'($urandom_range(0, 3));
            cycle(acc);
        end
        check("small cntB saturates", 32'(bs.cntB), 32'd3);
        check("main cntB after 5", 32'(bm.cntB), 32'd5);
        bm.clr_cnt = 1'b1;
        cycle(acc);
        check("clr over accept small", 32'(bs.cntB), 32'd0);
        check("clr over accept main", 32'(bm.cntB), 32'd0);
        bm.clr_cnt = 1'b0;

        // Randomized traffic; a stalled beat is held until accepted.
        stalled = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!stalled) begin
                bm.in_valid = ($urandom_range(0, 3) != 0);
                bm.in_sel   = 1'($urandom_range(0, 1));
                bm.in_data  = 2'($urandom_range(0, 3));
            end
            bm.outA_ready = ($urandom_range(0, 2) != 0);
            bm.outB_ready = ($urandom_range(0, 2) != 0);
            bm.clr_cnt    = ($urandom_range(0, 31) == 0);
            cycle(acc);
            stalled = bm.in_valid && !acc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
